// File: rtl/lbp_engine.sv
// 3x3 Local Binary Pattern engine: streams a raster gray image through a
// 2*IMG_W+3 pixel window buffer and writes one 8-bit code per pixel.

module lbp_nbr #(
  parameter int DW  = 8,
  parameter int POS = 0
) (
  input  logic [8:0][DW-1:0] win,
  input  logic               top,
  input  logic               bot,
  input  logic               lft,
  input  logic               rgt,
  output logic               hit
);
  localparam int R = POS / 3;
  localparam int C = POS % 3;

  logic [1:0] r, c;
  logic [3:0] sel;

  // Out-of-image taps fold back onto the centre row/column (edge replicate).
  always_comb begin
    r = 2'(R);
    c = 2'(C);
    if ((top && R == 0) || (bot && R == 2)) r = 2'd1;
    if ((lft && C == 0) || (rgt && C == 2)) c = 2'd1;
    sel = 4'(r) * 4'd3 + 4'(c);
    hit = win[sel] >= win[4];
  end
endmodule

module lbp_engine #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          border_mode,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);
  localparam int N   = IMG_W * IMG_H;
  localparam int CW  = AW + 1;
  localparam int SRL = 2 * IMG_W + 3;
  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

  state_t               state, state_nxt;
  logic                 mode;
  logic [CW-1:0]        rd_cnt, sh_cnt;
  logic                 rd_pend, emit_pend;
  logic [SRL-1:0][DW-1:0] sr;
  logic [XW-1:0]        col;
  logic [YW-1:0]        row;
  logic [AW-1:0]        pix;
  logic                 shift;
  logic [DW-1:0]        shift_px;
  logic [8:0][DW-1:0]   win;
  logic [7:0]           nb;
  logic                 top, bot, lft, rgt;
  logic [7:0]           code;

  assign gray_req  = (state == FILL || state == RUN) && gray_ready && (rd_cnt < CW'(N));
  assign gray_addr = rd_cnt[AW-1:0];

  // After the last read, W+1 filler pixels push the tail of the image through
  // the window; fillers only ever land on taps that border clamping discards.
  assign shift    = rd_pend || (state == FLUSH && sh_cnt < CW'(N + IMG_W + 1));
  assign shift_px = rd_pend ? gray_data : '0;

  // sr[0] holds pixel q; the window centre is pixel q-IMG_W-1.
  for (genvar g = 0; g < 9; g++) begin : g_win
    assign win[g] = sr[(2 - g / 3) * IMG_W + (2 - g % 3)];
  end

  assign top = (row == '0);
  assign bot = (row == YW'(IMG_H - 1));
  assign lft = (col == '0);
  assign rgt = (col == XW'(IMG_W - 1));

  for (genvar g = 0; g < 8; g++) begin : g_nb
    lbp_nbr #(.DW(DW), .POS(g < 4 ? g : g + 1)) u_nb (
      .win (win),
      .top (top),
      .bot (bot),
      .lft (lft),
      .rgt (rgt),
      .hit (nb[g])
    );
  end

  assign code = ((top || bot || lft || rgt) && !mode) ? 8'h00 : nb;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gray_ready) state_nxt = FILL;
      FILL:    if (rd_cnt >= CW'(IMG_W + 2)) state_nxt = RUN;
      RUN:     if (rd_cnt == CW'(N)) state_nxt = FLUSH;
      FLUSH:   if (lbp_valid && lbp_addr == AW'(N - 1)) state_nxt = DONE;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mode      <= 1'b0;
      rd_cnt    <= '0;
      sh_cnt    <= '0;
      rd_pend   <= 1'b0;
      emit_pend <= 1'b0;
      sr        <= '0;
      col       <= '0;
      row       <= '0;
      pix       <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && gray_ready) mode <= border_mode;
      rd_pend <= gray_req;
      if (gray_req) rd_cnt <= rd_cnt + 1'b1;
      if (shift) begin
        sr     <= {sr[SRL-2:0], shift_px};
        sh_cnt <= sh_cnt + 1'b1;
      end
      emit_pend <= shift && (sh_cnt >= CW'(IMG_W + 1));
      lbp_valid <= emit_pend;
      if (emit_pend) begin
        lbp_addr <= pix;
        lbp_data <= code;
        pix      <= pix + 1'b1;
        if (rgt) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (lbp_valid && lbp_addr == AW'(N - 1)) finish <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lbp_engine.sv
// Bench for lbp_engine: an 8x8 and a 128x128 instance, host memory models,
// a bus monitor and a 2-D reference LBP model.

module tb_lbp_engine;
  localparam int AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst [2];
  logic          bmode [2];
  logic          gray_ready [2];
  logic          gray_req [2];
  logic [AW-1:0] gray_addr [2];
  logic [7:0]    gray_data [2];
  logic          lbp_valid [2];
  logic [AW-1:0] lbp_addr [2];
  logic [7:0]    lbp_data [2];
  logic          fin [2];

  logic [7:0] img [2][16384];
  logic [7:0] got [2][16384];
  bit         rnd_rdy [2], rdy_lvl [2], fmode [2];
  int         rd_exp [2], wr_exp [2], viol [2], ord_err [2], cyc [2], last_cyc [2], fin_bad [2];
  bit         fin_prev [2], prev_last [2];
  int         checks = 0, errors = 0;

  typedef struct {
    int         pat;
    bit         mode;
    int         addr;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [12];

  lbp_engine #(.IMG_W(8), .IMG_H(8), .DW(8), .AW(AW)) dut8 (
    .clk(clk), .reset(rst[0]), .border_mode(bmode[0]), .gray_ready(gray_ready[0]),
    .gray_req(gray_req[0]), .gray_addr(gray_addr[0]), .gray_data(gray_data[0]),
    .lbp_valid(lbp_valid[0]), .lbp_addr(lbp_addr[0]), .lbp_data(lbp_data[0]), .finish(fin[0]));

  lbp_engine #(.IMG_W(128), .IMG_H(128), .DW(8), .AW(AW)) dut128 (
    .clk(clk), .reset(rst[1]), .border_mode(bmode[1]), .gray_ready(gray_ready[1]),
    .gray_req(gray_req[1]), .gray_addr(gray_addr[1]), .gray_data(gray_data[1]),
    .lbp_valid(lbp_valid[1]), .lbp_addr(lbp_addr[1]), .lbp_data(lbp_data[1]), .finish(fin[1]));

  function automatic int wid(input int d);
    return (d != 0) ? 128 : 8;
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [7:0] ref_code(input int d, input int y, input int x, input bit m);
    int w;
    int k;
    logic [7:0] c;
    logic [7:0] gc;
    w = wid(d);
    c = 8'h00;
    k = 0;
    if (!m && (y == 0 || y == w - 1 || x == 0 || x == w - 1)) return 8'h00;
    gc = img[d][y * w + x];
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dy != 0 || dx != 0) begin
          if (img[d][clampi(y + dy, w - 1) * w + clampi(x + dx, w - 1)] >= gc) c[k] = 1'b1;
          k++;
        end
    return c;
  endfunction

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Host memory: data valid the cycle after the request.
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      if (gray_req[d] === 1'b1) gray_data[d] <= img[d][gray_addr[d]];

  initial forever begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      gray_ready[d] = rnd_rdy[d] ? ($urandom_range(0, 3) != 0) : rdy_lvl[d];
  end

  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        rd_exp[d] = 0; wr_exp[d] = 0; viol[d] = 0; ord_err[d] = 0;
        cyc[d] = 0; last_cyc[d] = 0; fin_bad[d] = 0; fin_prev[d] = 0; prev_last[d] = 0;
      end else begin
        cyc[d]++;
        if (gray_req[d] && !gray_ready[d]) viol[d]++;
        if (gray_req[d]) begin
          if (int'(gray_addr[d]) != rd_exp[d]) ord_err[d]++;
          rd_exp[d]++;
        end
        if (lbp_valid[d]) begin
          if (int'(lbp_addr[d]) != wr_exp[d]) ord_err[d]++;
          else got[d][wr_exp[d]] = lbp_data[d];
          wr_exp[d]++;
          last_cyc[d] = cyc[d];
        end
        if (fin[d] && !fin_prev[d] && !prev_last[d]) fin_bad[d]++;
        fin_prev[d]  = fin[d];
        prev_last[d] = lbp_valid[d] && int'(lbp_addr[d]) == wid(d) * wid(d) - 1;
      end
    end

  task automatic start_frame(input int d, input int pat, input bit mode, input bit rnd);
    int n;
    n = wid(d) * wid(d);
    @(posedge clk);
    #1;
    rst[d] = 1'b1; bmode[d] = mode; fmode[d] = mode; rnd_rdy[d] = rnd; rdy_lvl[d] = 1'b1;
    for (int a = 0; a < n; a++) begin
      got[d][a] = 8'hxx;
      case (pat)
        0:       img[d][a] = 8'h55;
        1:       img[d][a] = 8'(a);
        default: img[d][a] = 8'($urandom_range(0, 255));
      endcase
    end
    @(posedge clk);
    #1;
    rst[d] = 1'b0;
  endtask

  task automatic finish_frame(input int d, input string nm, input bit rnd);
    int n, w, budget, k, mism;
    w = wid(d);
    n = w * w;
    budget = rnd ? 4 * n + 500 : n + 2 * w + 100;
    k = 0;
    mism = 0;
    while (fin[d] !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(fin[d] === 1'b1, {nm, " finish"}, (fin[d] === 1'b1) ? 1 : 0, 1);
    @(negedge clk);
    for (int a = 0; a < n; a++)
      if (got[d][a] !== ref_code(d, a / w, a % w, fmode[d])) mism++;
    chk(mism == 0, {nm, " code mismatches"}, mism, 0);
    chk(wr_exp[d] == n, {nm, " write count"}, wr_exp[d], n);
    chk(rd_exp[d] == n, {nm, " read count"}, rd_exp[d], n);
    chk(ord_err[d] == 0, {nm, " address order errors"}, ord_err[d], 0);
    chk(viol[d] == 0, {nm, " req while not ready"}, viol[d], 0);
    chk(fin_bad[d] == 0, {nm, " finish timing"}, fin_bad[d], 0);
    if (!rnd) chk(last_cyc[d] <= n + 2 * w + 17, {nm, " latency"}, last_cyc[d], n + 2 * w + 17);
  endtask

  initial begin
    int k, bad;
    tbl[0]  = '{0, 1'b0, 0,  8'h00};
    tbl[1]  = '{0, 1'b0, 9,  8'hFF};
    tbl[2]  = '{0, 1'b0, 27, 8'hFF};
    tbl[3]  = '{0, 1'b0, 63, 8'h00};
    tbl[4]  = '{0, 1'b1, 0,  8'hFF};
    tbl[5]  = '{1, 1'b0, 9,  8'hF0};
    tbl[6]  = '{1, 1'b0, 0,  8'h00};
    tbl[7]  = '{1, 1'b0, 56, 8'h00};
    tbl[8]  = '{1, 1'b1, 0,  8'hFF};
    tbl[9]  = '{1, 1'b1, 63, 8'hD0};
    tbl[10] = '{1, 1'b1, 9,  8'hF0};
    tbl[11] = '{1, 1'b1, 7,  8'hF6};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; bmode[d] = 1'b0; rnd_rdy[d] = 1'b0; rdy_lvl[d] = 1'b0; gray_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(gray_req[d] === 1'b0, "reset gray_req", int'(gray_req[d]), 0);
      chk(gray_addr[d] === '0, "reset gray_addr", int'(gray_addr[d]), 0);
      chk(lbp_valid[d] === 1'b0, "reset lbp_valid", int'(lbp_valid[d]), 0);
      chk(lbp_addr[d] === '0, "reset lbp_addr", int'(lbp_addr[d]), 0);
      chk(lbp_data[d] === '0, "reset lbp_data", int'(lbp_data[d]), 0);
      chk(fin[d] === 1'b0, "reset finish", int'(fin[d]), 0);
    end
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (gray_req[0] !== 1'b0 || lbp_valid[0] !== 1'b0) bad++;
    end
    chk(bad == 0, "idle without ready", bad, 0);

    foreach (tbl[i]) begin
      start_frame(0, tbl[i].pat, tbl[i].mode, 1'b0);
      finish_frame(0, "table frame", 1'b0);
      chk(got[0][tbl[i].addr] === tbl[i].exp, $sformatf("table[%0d] addr %0d", i, tbl[i].addr),
          int'(got[0][tbl[i].addr]), int'(tbl[i].exp));
    end

    // Nothing may move once finish is up, even with the host ready.
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (gray_req[0] !== 1'b0 || lbp_valid[0] !== 1'b0 || fin[0] !== 1'b1) bad++;
    end
    chk(bad == 0, "quiet after finish", bad, 0);

    for (int r = 0; r < 4; r++) begin
      start_frame(0, 2, r[0], 1'b1);
      finish_frame(0, "random 8x8 stalled", 1'b1);
    end

    // Reset after write 20, then the frame must restart cleanly from 0.
    start_frame(0, 1, 1'b0, 1'b0);
    k = 0;
    while (wr_exp[0] < 21 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(wr_exp[0] >= 21, "reach write 20", wr_exp[0], 21);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    @(negedge clk);
    bad = 0;
    if (gray_req[0] !== 1'b0 || gray_addr[0] !== '0 || lbp_valid[0] !== 1'b0 ||
        lbp_addr[0] !== '0 || lbp_data[0] !== '0 || fin[0] !== 1'b0) bad = 1;
    chk(bad == 0, "outputs after mid-frame reset", bad, 0);
    finish_frame(0, "rerun after reset", 1'b0);

    // Large frame with a stalling host; border_mode flips must be ignored.
    start_frame(1, 2, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    bmode[1] = 1'b0;
    finish_frame(1, "random 128x128 stalled", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
